serial_add_seq: RTL and testbench

Bit-serial adder sequencer for the ALU datapath. It wraps one instance of the team's 1-bit full-adder cell. Each cycle it feeds the cell one operand bit pair plus the registered carry, then collects the cell's sum bit and carry-out. A WIDTH-bit addition completes in WIDTH cycles using a single adder cell, trading latency for area against the ripple-carry ALU.

---
 rtl/serial_add_seq.sv | 143 ++++++++++++++
 tb/tb_serial_add_seq.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial adder sequencer around one 1-bit full-adder cell.
// A WIDTH-bit add takes WIDTH cycles. Each cycle the cell sees one operand bit
// pair plus the registered carry. The sum bit shifts in from the MSB side.
//
// Optional feature: define SERIAL_SUB_EN to add the `sub` input. sub=1 computes
// a-b mod 2^WIDTH (b inverted, carry forced to 1, cin ignored); cout=1 = no borrow.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, sampled only in IDLE
//   a, b   WIDTH-bit operands, captured on the accepting edge
//   sub    (SERIAL_SUB_EN only) subtract select, captured with the operands
//   cin    carry-in, captured on the accepting edge
//   busy   high while the sequencer is in RUN
//   done   one-cycle pulse, result valid
//   sum    WIDTH-bit result, held from done until the next accepted start
//   cout   final carry-out, held with sum

// One-bit full-adder cell.
module serial_add_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module serial_add_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic [WIDTH-1:0]   w_b_load;
    logic               w_c_load;
    logic               w_s;
    logic               w_co;

    // Operand B / carry values loaded on the accepting edge.
`ifdef SERIAL_SUB_EN
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub ? 1'b1 : cin;
`else
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    serial_add_fa u_fa (
        .i_a (r_a_sr[0]),
        .i_b (r_b_sr[0]),
        .i_c (r_carry),
        .o_s (w_s),
        .o_c (w_co)
    );

    // Sequencer state, datapath shift registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= w_b_load;
                        r_carry <= w_c_load;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    // Last bit: latch the final carry and raise done next cycle.
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_cout  <= w_co;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq: WIDTH=8 directed scenarios plus
// randomized WIDTH=2 and WIDTH=32 runs checked against plain integer addition.
module tb_serial_add_seq;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
`ifdef SERIAL_SUB_EN
    logic       sub8, sub2, sub32;
`endif
    // WIDTH=2 instance
    logic       start2, cin2, busy2, done2, cout2;
    logic [1:0] a2, b2, sum2;
    // WIDTH=32 instance
    logic        start32, cin32, busy32, done32, cout32;
    logic [31:0] a32, b32, sum32;

    serial_add_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
`ifdef SERIAL_SUB_EN
        .sub(sub8),
`endif
        .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));

    serial_add_seq #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
`ifdef SERIAL_SUB_EN
        .sub(sub2),
`endif
        .cin(cin2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2));

    serial_add_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32),
`ifdef SERIAL_SUB_EN
        .sub(sub32),
`endif
        .cin(cin32), .busy(busy32), .done(done32), .sum(sum32), .cout(cout32));

    // Run one WIDTH=8 operation; returns result, latency and busy-cycle count.
    // Ends just after the edge that follows done, so a new start is accepted.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic sb, output logic [7:0] s, output logic co,
                       output int lat, output int bcnt);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
`ifdef SERIAL_SUB_EN
        sub8 = sb;
`endif
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0; bcnt = 0;
        while (!done8 && lat < 50) begin
            if (busy8) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        s = sum8; co = cout8;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
        start2 = 0; a2 = 0; b2 = 0; cin2 = 0;
        start32 = 0; a32 = 0; b32 = 0; cin32 = 0;
`ifdef SERIAL_SUB_EN
        sub8 = 0; sub2 = 0; sub32 = 0;
`endif
        #3;
        checks++;
        if ({busy8, done8, sum8, cout8} !== 11'd0) begin
            errors++;
            $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b, want all 0",
                     busy8, done8, sum8, cout8);
        end
        checks++;
        if ({busy2, done2, sum2, cout2, busy32, done32, sum32, cout32} !== 40'd0) begin
            errors++;
            $display("FAIL reset2_32: got sum2=%h sum32=%h busy2=%b busy32=%b, want 0",
                     sum2, sum32, busy2, busy32);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Single add with latency, busy duration and hold-after-done checks.
    task automatic test_basic();
        logic [7:0] s; logic co; int lat, bcnt;
        logic [8:0] exp;
        exp = 9'(8'h3C) + 9'(8'h15);
        op8(8'h3C, 8'h15, 1'b0, 1'b0, s, co, lat, bcnt);
        checks++;
        if ({co, s} !== exp) begin
            errors++;
            $display("FAIL basic_sum: got cout=%b sum=%h, want cout=%b sum=%h", co, s, exp[8], exp[7:0]);
        end
        checks++;
        if (lat != 8) begin
            errors++;
            $display("FAIL basic_latency: got %0d, want 8", lat);
        end
        checks++;
        if (bcnt != 8) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d, want 8", bcnt);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({done8, busy8, cout8, sum8} !== {2'b00, exp}) begin
                errors++;
                $display("FAIL basic_hold[%0d]: got done=%b busy=%b cout=%b sum=%h, want 0 0 %b %h",
                         i, done8, busy8, cout8, sum8, exp[8], exp[7:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    // Carry-boundary cases.
    task automatic test_carry();
        logic [7:0] s; logic co; int lat, bcnt;
        logic [7:0] av [2];
        logic [7:0] bv [2];
        logic       cv [2];
        logic [8:0] exp;
        av[0] = 8'hFF; bv[0] = 8'h01; cv[0] = 1'b0;
        av[1] = 8'hFF; bv[1] = 8'hFF; cv[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp = 9'(av[i]) + 9'(bv[i]) + 9'(cv[i]);
            op8(av[i], bv[i], cv[i], 1'b0, s, co, lat, bcnt);
            checks++;
            if ({co, s} !== exp) begin
                errors++;
                $display("FAIL carry[%0d]: got cout=%b sum=%h, want cout=%b sum=%h",
                         i, co, s, exp[8], exp[7:0]);
            end
        end
    endtask

    // start held high: three ops, operands scrambled while running.
    task automatic test_back_to_back();
        logic [7:0] av [3];
        logic [7:0] bv [3];
        logic       cv [3];
        int         dt [$];
        logic [8:0] got [$];
        logic [8:0] exp;
        for (int i = 0; i < 3; i++) begin
            av[i] = 8'($urandom); bv[i] = 8'($urandom); cv[i] = 1'($urandom);
        end
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            start8 = 1'b1;
            if (t % 10 == 0) begin
                a8 = av[t/10]; b8 = bv[t/10]; cin8 = cv[t/10];
            end else begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            end
            @(posedge clk); #1;
            if (done8) begin
                dt.push_back(t);
                got.push_back({cout8, sum8});
            end
        end
        @(negedge clk);
        start8 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (dt.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d done pulses, want 3", dt.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                exp = 9'(av[i]) + 9'(bv[i]) + 9'(cv[i]);
                checks++;
                if (got[i] !== exp) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: got %h, want %h", i, got[i], exp);
                end
                checks++;
                if (dt[i] != 8 + 10 * i) begin
                    errors++;
                    $display("FAIL b2b_timing[%0d]: done after edge %0d, want %0d", i, dt[i], 8 + 10 * i);
                end
            end
        end
    endtask

    // Reset in the middle of RUN aborts the op; the next op is correct.
    task automatic test_reset_mid();
        logic [7:0] s; logic co; int lat, bcnt;
        int         seen;
        logic [8:0] exp;
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, sum8, cout8} !== 11'd0) begin
            errors++;
            $display("FAIL midreset_clear: got busy=%b done=%b sum=%h cout=%b, want all 0",
                     busy8, done8, sum8, cout8);
        end
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done8) seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done8 || busy8) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midreset_no_done: got %0d done/busy samples, want 0", seen);
        end
        exp = 9'(8'h6D) + 9'(8'h92) + 9'(1'b1);
        op8(8'h6D, 8'h92, 1'b1, 1'b0, s, co, lat, bcnt);
        checks++;
        if ({co, s} !== exp || lat != 8) begin
            errors++;
            $display("FAIL midreset_next: got cout=%b sum=%h lat=%0d, want %b %h lat=8",
                     co, s, lat, exp[8], exp[7:0]);
        end
    endtask

    task automatic test_random_w2();
        logic [2:0] exp;
        int n;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom); start2 = 1'b1;
            exp = 3'(a2) + 3'(b2) + 3'(cin2);
            @(posedge clk); #1;
            start2 = 1'b0;
            a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
            n = 0;
            while (!done2 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            checks++;
            if (!done2 || {cout2, sum2} !== exp || n != 2) begin
                errors++;
                $display("FAIL rand_w2[%0d]: got done=%b {cout,sum}=%h lat=%0d, want %h lat=2",
                         k, done2, {cout2, sum2}, n, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random_w32();
        logic [32:0] exp;
        int n;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom); start32 = 1'b1;
            if (k == 0) begin a32 = 32'hFFFF_FFFF; b32 = 32'h0; cin32 = 1'b1; end
            exp = 33'(a32) + 33'(b32) + 33'(cin32);
            @(posedge clk); #1;
            start32 = 1'b0;
            n = 0;
            while (!done32 && n < 60) begin
                @(posedge clk); #1;
                n++;
            end
            checks++;
            if (!done32 || {cout32, sum32} !== exp || n != 32) begin
                errors++;
                $display("FAIL rand_w32[%0d]: got done=%b {cout,sum}=%h lat=%0d, want %h lat=32",
                         k, done32, {cout32, sum32}, n, exp);
            end
            @(posedge clk); #1;
        end
    endtask

`ifdef SERIAL_SUB_EN
    // Subtraction: result a-b mod 256, cout=1 when a>=b.
    task automatic test_sub();
        logic [7:0] s; logic co; int lat, bcnt;
        logic [7:0] av, bv;
        logic [8:0] exp;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) begin av = 8'h05; bv = 8'h07; end
            else if (i == 1) begin av = 8'h07; bv = 8'h05; end
            else begin av = 8'($urandom); bv = 8'($urandom); end
            exp[7:0] = av - bv;
            exp[8]   = (av >= bv);
            op8(av, bv, 1'($urandom), 1'b1, s, co, lat, bcnt);
            checks++;
            if ({co, s} !== exp) begin
                errors++;
                $display("FAIL sub[%0d]: a=%h b=%h got cout=%b sum=%h, want cout=%b sum=%h",
                         i, av, bv, co, s, exp[8], exp[7:0]);
            end
        end
        sub8 = 1'b0;
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_reset_mid();
`ifdef SERIAL_SUB_EN
        test_sub();
`endif
        test_random_w2();
        test_random_w32();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
